// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the fetch and data ports.
// Optional macro MEM_ARB_RR_EN selects round-robin on simultaneous requests instead of data-first.
module mem_arbiter #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic        iGnt,
    output logic        iRvalid,
    output logic [31:0] iRdata,
    input  logic        dReq,
    input  logic        dWen,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    output logic        dGnt,
    output logic        dRvalid,
    output logic [31:0] dRdata,
    output logic        memEn,
    output logic        memWen,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               own, own_n;
    logic               last, last_n;
    logic               resp;
    logic               issue_win;
    logic               pick_d;

    // State register; own/last: 0 = fetch, 1 = data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            own   <= 1'b0;
            last  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            own   <= own_n;
            last  <= last_n;
        end
    end

    // Issue window is IDLE or the response cycle; everything is held at 0 while rst is high.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        own_n     = own;
        last_n    = last;
        iGnt      = 1'b0;
        dGnt      = 1'b0;
        iRvalid   = 1'b0;
        dRvalid   = 1'b0;
        memEn     = 1'b0;
        memWen    = 1'b0;
        memAddr   = '0;
        memWdata  = '0;
        resp      = !rst && (state == BUSY) && (cnt == '0);
        issue_win = !rst && ((state == IDLE) || (cnt == '0));
`ifdef MEM_ARB_RR_EN
        pick_d    = dReq && (!iReq || !last);
`else
        pick_d    = dReq;
`endif
        iRvalid   = resp && !own;
        dRvalid   = resp && own;

        if (issue_win && (iReq || dReq)) begin
            memEn    = 1'b1;
            dGnt     = pick_d;
            iGnt     = !pick_d;
            memAddr  = pick_d ? dAddr : iAddr;
            memWen   = pick_d && dWen;
            memWdata = (pick_d && dWen) ? dWdata : DATA_W'(0);
            state_n  = BUSY;
            cnt_n    = CNT_W'(LATENCY - 1);
            own_n    = pick_d;
            last_n   = pick_d;
        end else if (state == BUSY) begin
            if (cnt != '0) begin
                cnt_n = cnt - CNT_W'(1);
            end else begin
                state_n = IDLE;
            end
        end
    end

    assign iRdata = memRdata;
    assign dRdata = memRdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiter instances (LATENCY 1 and 3), each with a memory model,
// a cycle-level reference model, directed scenarios and randomized requesters.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int lat, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (LATENCY=%0d) at %0t: got %h expected %h", name, lat, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Power-on memory contents, shared by the memory model and the reference model.
    function automatic logic [31:0] init_val(input logic [9:0] idx);
        return (idx == 10'd4) ? 32'h0050_0093 : 32'(idx) * 32'h9E37_79B1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int unsigned L = (g == 0) ? 1 : 3;

        logic        rst, iReq, dReq, dWen;
        logic [31:0] iAddr, dAddr, dWdata, memRdata;
        logic        iGnt, iRvalid, dGnt, dRvalid, memEn, memWen;
        logic [31:0] iRdata, dRdata, memAddr, memWdata;
        bit          fin = 1'b0;

        mem_arbiter #(.LATENCY(L)) dut (
            .clk(clk), .rst(rst),
            .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iRvalid(iRvalid), .iRdata(iRdata),
            .dReq(dReq), .dWen(dWen), .dAddr(dAddr), .dWdata(dWdata),
            .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata),
            .memEn(memEn), .memWen(memWen), .memAddr(memAddr), .memWdata(memWdata),
            .memRdata(memRdata)
        );

        // Memory: samples at the issue edge, read data appears L cycles later.
        logic [31:0] mem [0:1023];
        bit          mem_wr [0:1023];
        logic [31:0] pipe [0:15];
        always @(posedge clk) begin
            if (memEn && memWen) begin
                mem[memAddr[11:2]]    <= memWdata;
                mem_wr[memAddr[11:2]] <= 1'b1;
            end
            pipe[0] <= !memEn ? 32'h0 :
                       (mem_wr[memAddr[11:2]] ? mem[memAddr[11:2]] : init_val(memAddr[11:2]));
            for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
        end
        assign memRdata = pipe[L-1];

        // Reference model: absolute response time of the single outstanding access.
        logic [31:0] ref_mem [0:1023];
        bit          ref_wr [0:1023];
        longint      cyc = 0;
        longint      resp_at = -1;
        bit          own_m = 1'b0, last_m = 1'b0, rd_m = 1'b0;
        logic [31:0] exp_data = 32'h0;

        always @(negedge clk) begin
            bit          ig, dg, iv, dv, take_d;
            logic [31:0] ea, ew;
            logic [9:0]  idx;
            ig = 1'b0; dg = 1'b0; iv = 1'b0; dv = 1'b0; take_d = 1'b0;
            ea = 32'h0; ew = 32'h0; idx = 10'h0;
            if (rst) begin
                resp_at = -1;
                last_m  = 1'b0;
            end else begin
                if (resp_at == cyc) begin
                    iv = !own_m;
                    dv = own_m;
                end
                if (resp_at <= cyc && (iReq || dReq)) begin
`ifdef MEM_ARB_RR_EN
                    if (iReq && dReq) take_d = (last_m == 1'b0);
                    else              take_d = dReq;
`else
                    take_d = dReq;
`endif
                    dg = take_d;
                    ig = !take_d;
                    ea = take_d ? dAddr : iAddr;
                    ew = (take_d && dWen) ? dWdata : 32'h0;
                end
            end
            check("ctl{iGnt,dGnt,memEn,memWen,iRv,dRv}", L,
                  32'({iGnt, dGnt, memEn, memWen, iRvalid, dRvalid}),
                  32'({ig, dg, ig | dg, dg & dWen, iv, dv}));
            check("memAddr", L, memAddr, ea);
            check("memWdata", L, memWdata, ew);
            if (iv)         check("iRdata", L, iRdata, exp_data);
            if (dv && rd_m) check("dRdata", L, dRdata, exp_data);
            if (ig || dg) begin
                idx = ea[11:2];
                if (dg && dWen) begin
                    ref_mem[idx] = dWdata;
                    ref_wr[idx]  = 1'b1;
                end
                rd_m     = !(dg && dWen);
                exp_data = ref_wr[idx] ? ref_mem[idx] : init_val(idx);
                resp_at  = cyc + longint'(L);
                own_m    = dg;
                last_m   = dg;
            end
            cyc++;
        end

        initial begin
            bit exp_d;
            bit ig_s, dg_s;
            rst = 1'b1; iReq = 1'b0; dReq = 1'b0; dWen = 1'b0;
            iAddr = 32'h0; dAddr = 32'h0; dWdata = 32'h0;
            step();
            check("reset_outputs", L,
                  32'({iGnt, dGnt, iRvalid, dRvalid, memEn, memWen}), 32'h0);
            check("reset_addr_wdata", L, memAddr | memWdata, 32'h0);
            step();
            rst = 1'b0;

            // Both requesters held; order depends on the priority scheme (last = fetch after reset).
            step();
            iReq = 1'b1; iAddr = 32'h8; dReq = 1'b1; dWen = 1'b0; dAddr = 32'h100;
            #1;
            for (int n = 0; n < 4; n++) begin
`ifdef MEM_ARB_RR_EN
                exp_d = (n % 2 == 0);
`else
                exp_d = 1'b1;
`endif
                check("both_gnt", L, 32'({iGnt, dGnt}), 32'({!exp_d, exp_d}));
                for (int k = 1; k <= L; k++) begin
                    step();
                    if (n == 3 && k == L) dReq = 1'b0;
                    #1;
                    if (k < L) check("both_wait", L, 32'({iGnt, dGnt, iRvalid, dRvalid}), 32'h0);
                end
                check("both_rvalid", L, 32'({iRvalid, dRvalid}), 32'({!exp_d, exp_d}));
            end
            check("fetch_after_data", L, 32'({iGnt, dGnt}), 32'b10);
            for (int k = 1; k <= L; k++) begin step(); iReq = 1'b0; #1; end

            // Single fetch at 0x10.
            step();
            iReq = 1'b1; iAddr = 32'h10;
            #1;
            check("fetch_gnt", L, 32'({iGnt, dGnt, memEn}), 32'b101);
            check("fetch_addr", L, memAddr, 32'h10);
            for (int k = 1; k <= L; k++) begin
                step(); iReq = 1'b0; #1;
                check("fetch_rvalid", L, 32'(iRvalid), 32'(k == L));
            end
            check("fetch_rdata", L, iRdata, 32'h0050_0093);

            // Write 0xDEADBEEF to 0x200, then read it back.
            step();
            dReq = 1'b1; dWen = 1'b1; dAddr = 32'h200; dWdata = 32'hDEAD_BEEF;
            #1;
            check("wr_strobe", L, 32'({dGnt, memEn, memWen}), 32'b111);
            check("wr_wdata", L, memWdata, 32'hDEAD_BEEF);
            for (int k = 1; k <= L; k++) begin
                step(); dReq = 1'b0; dWen = 1'b0; dWdata = 32'h0; #1;
                check("wr_ack", L, 32'(dRvalid), 32'(k == L));
            end
            step();
            dReq = 1'b1; dWen = 1'b0; dAddr = 32'h200;
            #1;
            check("rd_strobe", L, 32'({dGnt, memEn, memWen}), 32'b110);
            check("rd_wdata", L, memWdata, 32'h0);
            for (int k = 1; k <= L; k++) begin step(); dReq = 1'b0; #1; end
            check("rd_rvalid", L, 32'(dRvalid), 32'd1);
            check("rd_rdata", L, dRdata, 32'hDEAD_BEEF);

            // Back-to-back fetches at 0x0 and 0x4 with no bubble.
            step();
            iReq = 1'b1; iAddr = 32'h0;
            #1;
            check("b2b_gnt0", L, 32'(iGnt), 32'd1);
            for (int k = 1; k <= L; k++) begin
                step(); if (k == L) iAddr = 32'h4; #1;
                check("b2b_gnt1", L, 32'({iGnt, iRvalid, dRvalid}), (k == L) ? 32'b110 : 32'b000);
            end
            check("b2b_rdata0", L, iRdata, 32'h0);
            check("b2b_addr1", L, memAddr, 32'h4);
            for (int k = 1; k <= L; k++) begin
                step(); iReq = 1'b0; #1;
                check("b2b_rvalid1", L, 32'({iRvalid, dRvalid}), (k == L) ? 32'b10 : 32'b00);
            end
            check("b2b_rdata1", L, iRdata, 32'h9E37_79B1);

            // Reset one cycle after a read grant drops the access.
            step();
            dReq = 1'b1; dWen = 1'b0; dAddr = 32'h40;
            #1;
            check("rm_gnt", L, 32'(dGnt), 32'd1);
            step(); dReq = 1'b0; rst = 1'b1; #1;
            check("rm_zero", L, 32'({iGnt, dGnt, iRvalid, dRvalid, memEn, memWen}), 32'h0);
            check("rm_addr", L, memAddr | memWdata, 32'h0);
            step(); rst = 1'b0; dReq = 1'b1; dAddr = 32'h44; #1;
            check("rm_fresh_gnt", L, 32'(dGnt), 32'd1);
            for (int k = 1; k <= L; k++) begin
                step(); dReq = 1'b0; #1;
                check("rm_rvalid", L, 32'(dRvalid), 32'(k == L));
            end
            check("rm_rdata", L, dRdata, init_val(10'd17));

            // Randomized requesters obeying the hold-until-granted protocol.
            ig_s = 1'b0; dg_s = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                step();
                rst = ($urandom_range(0, 149) == 0);
                if (ig_s || !iReq || $urandom_range(0, 31) == 0) begin
                    iReq  = ($urandom_range(0, 2) != 0);
                    iAddr = $urandom & 32'hFFFF_FFFC;
                end
                if (dg_s || !dReq || $urandom_range(0, 31) == 0) begin
                    dReq   = ($urandom_range(0, 2) != 0);
                    dWen   = $urandom_range(0, 1) == 1;
                    dAddr  = {20'($urandom), 10'($urandom_range(0, 15)), 2'b00};
                    dWdata = $urandom;
                end
                #1;
                ig_s = iGnt;
                dg_s = dGnt;
            end
            step();
            rst = 1'b0; iReq = 1'b0; dReq = 1'b0;
            repeat (20) step();
            fin = 1'b1;
        end
    end

    initial begin
        int c;
        c = 0;
        while (!(h[0].fin && h[1].fin) && c < 60000) begin
            @(posedge clk);
            c++;
        end
        if (!(h[0].fin && h[1].fin)) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: stimulus did not complete within %0d cycles", c);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
